// File: rtl/control_ascensor.sv
`default_nettype none
// ============================================================================
// Module      : control_ascensor
// Description : Request dispatcher for a four-floor elevator. Latches hall and
//               cabin calls, chooses travel direction with a SCAN policy
//               (keep going while requests lie ahead, then reverse), issues
//               one-cycle en+sube/baja step strobes to the floor tracker, and
//               holds the door open for a fixed dwell at each served floor.
//               Optional build macro PUERTA_REABRIR_EN: a press for the
//               current floor while the door is open restarts the dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module control_ascensor #(
    parameter int T_VIAJE  = 16,
    parameter int T_PUERTA = 32,
    parameter int W_CNT    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] llamada,
    input  logic [3:0] cabina,
    input  logic [1:0] piso,
    output logic       en,
    output logic       sube,
    output logic       baja,
    output logic       puerta_abierta,
    output logic       dir,
    output logic [3:0] pendientes
);

    localparam logic [1:0] c_REPOSO   = 2'd0;
    localparam logic [1:0] c_MOVIENDO = 2'd1;
    localparam logic [1:0] c_ESPERA   = 2'd2;
    localparam logic [1:0] c_PUERTA   = 2'd3;

    localparam logic [W_CNT-1:0] c_FIN_VIAJE  = W_CNT'(T_VIAJE - 1);
    localparam logic [W_CNT-1:0] c_FIN_PUERTA = W_CNT'(T_PUERTA - 1);

    logic [1:0]       r_estado;
    logic [W_CNT-1:0] r_cnt;
    logic [3:0]       r_pend;
    logic             r_dir;
    logic             r_en;
    logic             r_sube;
    logic             r_baja;
    logic             r_puerta;

    logic [3:0] w_mask_piso;
    logic [3:0] w_mask_arriba;
    logic [3:0] w_mask_abajo;
    logic [3:0] w_req;
    logic       w_arriba;
    logic       w_abajo;
    logic       w_aqui;
    logic       w_pulsa_aqui;

    // One-hot of the current floor and masks of the floors above/below it
    assign w_mask_piso   = 4'b0001 << piso;
    assign w_mask_arriba = 4'b1110 << piso;
    assign w_mask_abajo  = ~(4'b1111 << piso);

    // New request set: everything latched so far plus this cycle's presses
    assign w_req        = r_pend | llamada | cabina;
    assign w_arriba     = |(r_pend & w_mask_arriba);
    assign w_abajo      = |(r_pend & w_mask_abajo);
    assign w_aqui       = |(r_pend & w_mask_piso);
    assign w_pulsa_aqui = |((llamada | cabina) & w_mask_piso);

    // Dispatcher FSM with request latch, shared timer and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado <= c_REPOSO;
            r_cnt    <= '0;
            r_pend   <= 4'b0000;
            r_dir    <= 1'b1;
            r_en     <= 1'b0;
            r_sube   <= 1'b0;
            r_baja   <= 1'b0;
            r_puerta <= 1'b0;
        end else begin
            // Step strobe is one cycle wide unless re-armed below
            r_en   <= 1'b0;
            r_sube <= 1'b0;
            r_baja <= 1'b0;
            r_pend <= w_req;
            case (r_estado)
                c_REPOSO: begin
                    if (w_aqui) begin
                        // Serve the current floor; its request is dropped on entry
                        r_estado <= c_PUERTA;
                        r_cnt    <= '0;
                        r_puerta <= 1'b1;
                        r_pend   <= w_req & ~w_mask_piso;
                    end else if (r_dir ? w_arriba : w_abajo) begin
                        // Work remains in the current direction: keep going
                        r_estado <= c_MOVIENDO;
                        r_cnt    <= '0;
                    end else if (r_dir ? w_abajo : w_arriba) begin
                        // Nothing ahead but something behind: reverse
                        r_dir    <= ~r_dir;
                        r_estado <= c_MOVIENDO;
                        r_cnt    <= '0;
                    end
                end
                c_MOVIENDO: begin
                    if (r_cnt == c_FIN_VIAJE) begin
                        r_en     <= 1'b1;
                        r_sube   <= r_dir;
                        r_baja   <= ~r_dir;
                        r_estado <= c_ESPERA;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ESPERA: begin
                    // Tracker updates piso at the end of this cycle
                    r_estado <= c_REPOSO;
                    r_cnt    <= '0;
                end
                c_PUERTA: begin
                    // Presses for the floor being served are never latched
                    r_pend <= w_req & ~w_mask_piso;
`ifdef PUERTA_REABRIR_EN
                    if (w_pulsa_aqui) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_FIN_PUERTA) begin
                        r_estado <= c_REPOSO;
                        r_cnt    <= '0;
                        r_puerta <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    if (r_cnt == c_FIN_PUERTA) begin
                        r_estado <= c_REPOSO;
                        r_cnt    <= '0;
                        r_puerta <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_estado <= c_REPOSO;
                    r_cnt    <= '0;
                    r_puerta <= 1'b0;
                end
            endcase
        end
    end

`ifndef PUERTA_REABRIR_EN
    // Same-floor presses during the dwell have no effect in this build
    logic w_sin_uso;
    assign w_sin_uso = w_pulsa_aqui;
`endif

    assign en             = r_en;
    assign sube           = r_sube;
    assign baja           = r_baja;
    assign puerta_abierta = r_puerta;
    assign dir            = r_dir;
    assign pendientes     = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_control_ascensor.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_ascensor
// Description : Self-checking bench for control_ascensor. A floor tracker and
//               a countdown-based reference model of the dispatcher run next
//               to the DUT; directed scenarios are followed by random presses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_ascensor;

    localparam int TV = 4;
    localparam int TP = 8;
`ifdef PUERTA_REABRIR_EN
    localparam int EXP_DWELL = 14;
`else
    localparam int EXP_DWELL = 8;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_TRAV = 1;
    localparam int PH_DOOR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] llamada = 4'b0;
    logic [3:0] cabina = 4'b0;
    logic [1:0] piso;
    logic [1:0] piso_init = 2'd0;
    logic       en, sube, baja, puerta_abierta, dir;
    logic [3:0] pendientes;

    control_ascensor #(.T_VIAJE(TV), .T_PUERTA(TP), .W_CNT(8)) dut (
        .clk(clk), .rst(rst), .llamada(llamada), .cabina(cabina), .piso(piso),
        .en(en), .sube(sube), .baja(baja), .puerta_abierta(puerta_abierta),
        .dir(dir), .pendientes(pendientes)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus cycles-left countdown; a travel span covers
    // the timer cycles and the settle cycle, with the strobe on its last cycle
    int         m_phase;
    int         m_left;
    logic [3:0] m_pend;
    logic       m_dir, m_en, m_sube, m_baja, m_door;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= PH_IDLE; m_left <= 0; m_pend <= 4'b0; m_dir <= 1'b1;
            m_en <= 1'b0; m_sube <= 1'b0; m_baja <= 1'b0; m_door <= 1'b0;
            piso <= piso_init;
        end else begin : model
            logic [3:0] req, here, press;
            int f;
            bit up, dn;
            req = m_pend | llamada | cabina;
            press = llamada | cabina;
            f = int'(piso);
            here = 4'(1 << f);
            up = 0; dn = 0;
            for (int j = 0; j < 4; j++) begin
                if (m_pend[j] && j > f) up = 1;
                if (m_pend[j] && j < f) dn = 1;
            end
            if (m_en) piso <= m_sube ? piso + 2'd1 : piso - 2'd1;
            m_en <= 1'b0; m_sube <= 1'b0; m_baja <= 1'b0;
            m_pend <= req;
            case (m_phase)
                PH_IDLE: begin
                    if ((m_pend & here) != 0) begin
                        m_phase <= PH_DOOR; m_left <= TP; m_door <= 1'b1;
                        m_pend <= req & ~here;
                    end else if ((m_dir && up) || (!m_dir && dn)) begin
                        m_phase <= PH_TRAV; m_left <= TV + 1;
                    end else if (up || dn) begin
                        m_dir <= !m_dir; m_phase <= PH_TRAV; m_left <= TV + 1;
                    end
                end
                PH_TRAV: begin
                    if (m_left == 2) begin
                        m_en <= 1'b1; m_sube <= m_dir; m_baja <= !m_dir;
                    end
                    if (m_left == 1) m_phase <= PH_IDLE;
                    m_left <= m_left - 1;
                end
                default: begin
                    m_pend <= req & ~here;
`ifdef PUERTA_REABRIR_EN
                    if ((press & here) != 0) m_left <= TP;
                    else
`endif
                    if (m_left == 1) begin
                        m_phase <= PH_IDLE; m_door <= 1'b0; m_left <= 0;
                    end else m_left <= m_left - 1;
                end
            endcase
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int en_count = 0;
    int door_run = 0;
    int last_len = 0;
    int door_rise = 0;
    int en_q[$];
    int door_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int seq_code(input int q[$]);
        int c = 0;
        foreach (q[i]) c = c * 5 + q[i] + 1;
        return c;
    endfunction

    task automatic check_all();
        chk("en", 32'(en), 32'(m_en));
        chk("sube", 32'(sube), 32'(m_sube));
        chk("baja", 32'(baja), 32'(m_baja));
        chk("puerta", 32'(puerta_abierta), 32'(m_door));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("pend", 32'(pendientes), 32'(m_pend));
        chk("sube_at_top", 32'(sube && piso == 2'd3), 0);
        chk("baja_at_bottom", 32'(baja && piso == 2'd0), 0);
        chk("door_and_en", 32'(puerta_abierta && en), 0);
        chk("step_without_en", 32'((sube || baja) && !en), 0);
    endtask

    // One cycle: wait for the falling edge, compare, update observed stats
    task automatic tick();
        @(negedge clk);
        cyc++;
        check_all();
        if (puerta_abierta) begin
            if (door_run == 0) begin
                door_q.push_back(int'(piso));
                door_rise = cyc;
            end
            door_run++;
        end else if (door_run != 0) begin
            last_len = door_run;
            door_run = 0;
        end
        if (en) begin
            en_count++;
            en_q.push_back(cyc);
        end
    endtask

    task automatic do_reset(input logic [1:0] floor);
        piso_init = floor;
        llamada = 4'b0;
        cabina = 4'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(en), 0);
        chk("rst_puerta", 32'(puerta_abierta), 0);
        chk("rst_dir", 32'(dir), 1);
        chk("rst_pend", 32'(pendientes), 0);
        rst = 1'b1;
        en_count = 0; door_run = 0; last_len = 0;
        en_q.delete(); door_q.delete();
    endtask

    task automatic press(input logic [3:0] ll, input logic [3:0] cb);
        llamada = ll; cabina = cb;
        tick();
        llamada = 4'b0; cabina = 4'b0;
    endtask

    initial begin
        int press_cyc;
        int n;

        // Two-floor trip from 0 to 2
        do_reset(2'd0);
        press(4'b0000, 4'b0100);
        repeat (40) tick();
        chk("s1_pulses", en_count, 2);
        chk("s1_spacing", (en_q.size() == 2) ? en_q[1] - en_q[0] : -1, 6);
        chk("s1_doors", seq_code(door_q), 3);
        chk("s1_dwell", last_len, TP);
        chk("s1_pend_clear", 32'(pendientes), 0);

        // At floor 1 going up with requests at 0 and 3
        do_reset(2'd1);
        press(4'b0000, 4'b1001);
        repeat (80) tick();
        chk("s2_doors", seq_code(door_q), 21);
        chk("s2_dir", 32'(dir), 0);
        chk("s2_floor", 32'(piso), 0);
        chk("s2_pulses", en_count, 5);

        // En-route pickup at floor 2 on the way to 3
        do_reset(2'd0);
        press(4'b0000, 4'b1000);
        repeat (3) tick();
        press(4'b0100, 4'b0000);
        repeat (60) tick();
        chk("s3_doors", seq_code(door_q), 19);

        // Same-floor request while idle
        do_reset(2'd2);
        press_cyc = cyc;
        press(4'b0100, 4'b0000);
        repeat (20) tick();
        chk("s4_pulses", en_count, 0);
        chk("s4_doors", seq_code(door_q), 3);
        chk("s4_latency", door_rise - press_cyc, 2);

        // Same-floor press during the dwell at count 5
        do_reset(2'd1);
        press(4'b0000, 4'b0010);
        n = 0;
        while (!puerta_abierta && n < 10) begin
            tick();
            n++;
        end
        chk("s5_door_timeout", 32'(puerta_abierta), 1);
        repeat (5) tick();
        press(4'b0000, 4'b0010);
        repeat (30) tick();
        chk("s5_dwell", last_len, EXP_DWELL);
        chk("s5_pend", 32'(pendientes), 0);

        // Reset while moving
        do_reset(2'd0);
        press(4'b0000, 4'b1000);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("s6_en", 32'(en), 0);
        chk("s6_sube", 32'(sube), 0);
        chk("s6_pend", 32'(pendientes), 0);
        check_all();
        do_reset(2'd0);
        repeat (30) tick();
        chk("s6_no_pulse", en_count, 0);
        chk("s6_no_door", door_q.size(), 0);

        // Random sparse presses against the model
        do_reset(2'd0);
        for (int i = 0; i < 1500; i++) begin
            llamada = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            cabina  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            tick();
        end
        llamada = 4'b0; cabina = 4'b0;
        repeat (200) tick();
        chk("rand_drained", 32'(pendientes), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
